// File: rtl/divider32_seq_pkg.sv
// Shared definitions for the sequential divider.
// Provides the default operand width and the FSM state encoding used by
// divider32_seq and its restoring-step datapath.
package divider32_seq_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } div_state_t;

endpackage

// File: rtl/divider32_seq_div_step.sv
// One restoring-division step, purely combinational.
// Ports:
//   p_in    - current partial remainder (WIDTH+1 bits)
//   q_in    - current quotient/dividend shift register
//   divisor - latched divisor
//   p_out   - partial remainder after the step
//   q_out   - quotient register after the step (new bit in LSB)
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   p_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   p_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;

  // P stays below the divisor between steps, so the shifted value fits in
  // WIDTH+1 bits; the extra top bit of the trial difference is the borrow.
  always_comb begin
    shifted = {p_in, q_in[WIDTH-1]};
    trial   = shifted - {2'b00, divisor};
    borrow  = trial[WIDTH+1];
    p_out   = borrow ? shifted[WIDTH:0] : trial[WIDTH:0];
    q_out   = {q_in[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/divider32_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n           - clock (rising edge), asynchronous active-low reset
//   start                - request pulse, accepted in IDLE or DONE
//   dividend, divisor    - operands, latched when start is accepted
//   busy                 - high while the division iterates (RUN)
//   done                 - one-cycle pulse when quotient/remainder are fresh
//   quotient, remainder  - results, held until the next accepted start
//   div_by_zero          - set when the last result had a zero divisor
module divider32_seq
  import divider32_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t state;
  div_state_t state_nxt;

  logic [WIDTH:0]   p;
  logic [WIDTH:0]   p_step;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] divisor_r;
  logic [CNT_W-1:0] count;

  logic accept;
  logic last_step;
  logic zero_div;

  // Start is only honoured outside RUN; a request during RUN is dropped.
  assign accept    = start && (state != ST_RUN);
  assign last_step = (state == ST_RUN) && (count == CNT_W'(1));
  assign zero_div  = (divisor == '0);

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p_in    (p),
    .q_in    (q),
    .divisor (divisor_r),
    .p_out   (p_step),
    .q_out   (q_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = zero_div ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_step) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (accept) begin
          state_nxt = zero_div ? ST_DONE : ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p           <= '0;
      q           <= '0;
      divisor_r   <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      p         <= '0;
      q         <= dividend;
      divisor_r <= divisor;
      count     <= CNT_W'(WIDTH);
      // A zero divisor bypasses iteration; the result is published at once.
      if (zero_div) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == ST_RUN) begin
      p     <= p_step;
      q     <= q_step;
      count <= count - CNT_W'(1);
      // Results are taken straight from the final step as DONE is entered.
      if (last_step) begin
        quotient    <= q_step;
        remainder   <= p_step[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: doc/divider32_seq.md
DIVIDER32_SEQ -- requirements
Module: divider32_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request pulse; sampled only when not busy.
REQ-005 SHALL have port dividend  input  WIDTH  unsigned dividend, sampled with accepted start.
REQ-006 SHALL have port divisor  input  WIDTH  unsigned divisor, sampled with accepted start.
REQ-007 SHALL have port busy  output  1  high while a division is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-009 SHALL have port quotient  output  WIDTH  unsigned quotient, held until the next accepted start.
REQ-010 SHALL have port remainder  output  WIDTH  unsigned remainder, held until the next accepted start.
REQ-011 SHALL have port div_by_zero  output  1  flag for the last result, held with quotient.

Function
REQ-012 SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-013 SHALL accept start in IDLE or DONE: latch operands, clear partial remainder P (WIDTH+1 bits), load step counter with WIDTH, go to RUN.
REQ-014 SHALL ignore start while in RUN, with no effect on state, operands or outputs.
REQ-015 SHALL, each RUN cycle, shift {P, Q} left one bit (dividend MSB enters P LSB), form trial = P - {0,divisor}; if no borrow, P = trial and Q LSB = 1, else P unchanged and Q LSB = 0.
REQ-016 SHALL decrement the counter each RUN cycle and go to DONE after exactly WIDTH RUN cycles.
REQ-017 SHALL assert done for exactly one cycle in DONE, WIDTH+1 cycles after the accepting edge, then return to IDLE unless a new start is accepted that cycle.
REQ-018 SHALL update quotient/remainder only on entry to DONE, with remainder = P[WIDTH-1:0], remainder < divisor.
REQ-019 SHALL, when latched divisor is zero, skip RUN, enter DONE on the next edge, and produce quotient all-ones, remainder = dividend, div_by_zero = 1.
REQ-020 SHALL clear div_by_zero on every non-zero-divisor result.
REQ-021 SHALL drive busy high in RUN and low in IDLE and DONE.
REQ-022 SHALL accept back-to-back start in DONE, making done and the new busy coincide with no idle cycle.

Reset
REQ-023 SHALL, on rst_n low, go to IDLE immediately regardless of clock, with busy, done, div_by_zero = 0 and quotient, remainder, P, Q, counter = 0.
REQ-024 SHALL abort an in-flight division on reset mid-RUN, with no done pulse for it.
REQ-025 SHALL ignore start in the first edge where rst_n is already high only if it was sampled low at that edge (no start accepted during reset).

Structure
REQ-026 SHALL take WIDTH default and state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) from the shared ALU definitions package/include.
REQ-027 SHALL put the one-bit restoring step (shift, trial subtract, select, quotient bit) in sub-module div_step, WIDTH+1 bits wide, combinational, instantiated once.
REQ-028 SHALL keep the counter, FSM and operand/result registers in divider32_seq.

Verification
REQ-029 SHALL pass this test: start with 100 / 7 -> done 33 cycles after the accepting edge, quotient 14, remainder 2, div_by_zero 0, busy high for 32 cycles.
REQ-030 SHALL pass this test: 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0; then 3 / 10 -> quotient 0, remainder 3.
REQ-031 SHALL pass this test: 5 / 0 -> done 1 cycle after acceptance, quotient 0xFFFFFFFF, remainder 5, div_by_zero 1; next 9 / 3 -> quotient 3, div_by_zero 0.
REQ-032 SHALL pass this test: start 50 / 5 pulsed again at RUN cycle 10 with 8 / 2 -> second start ignored, result quotient 10, remainder 0.
REQ-033 SHALL pass this test: rst_n low at RUN cycle 15 -> all outputs 0 within the reset assertion, no done; new 40 / 6 after release -> quotient 6, remainder 4.
REQ-034 SHALL pass this test: start held high across DONE -> second division starts in the DONE cycle, results 33 cycles apart.
